memory_arbiter: RTL
===================

# memory_arbiter

Shares the single actuator pattern memory port (8-bit address, 16-bit data, active-low enable/write/read strobes) between two requesters: the host path, which writes and reads pattern words from SPI-latched commands, and the scan path, which reads pattern words to drive actuator updates. A round-robin arbiter grants one access at a time, sequences the memory strobes, waits a fixed read latency, and returns captured read data to the owning requester with a one-cycle valid pulse. It sits directly in front of the memory macro; both requesters connect only through it.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- READ_LAT, 2, cycles from the read strobe to the data sample edge; legal range 1..7

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- host_req_n  in  1  host access request, held low until host_grant_n pulses
- host_write_n  in  1  0 = write, 1 = read; qualified with host_req_n
- host_address  in  ADDR_W  host access address
- host_wdata  in  DATA_W  host write data
- host_grant_n  out  1  one-cycle low pulse: host access issued this cycle
- host_rdata  out  DATA_W  last word read for host
- host_valid_n  out  1  one-cycle low pulse: host_rdata updated
- scan_req_n  in  1  scan read request, held low until scan_grant_n pulses
- scan_address  in  ADDR_W  scan read address
- scan_grant_n  out  1  one-cycle low pulse: scan access issued this cycle
- scan_rdata  out  DATA_W  last word read for scan
- scan_valid_n  out  1  one-cycle low pulse: scan_rdata updated
- memory_data_in  in  DATA_W  memory read data
- memory_enable_n  out  1  memory enable strobe
- memory_write_n  out  1  memory write strobe
- memory_read_n  out  1  memory read strobe
- memory_address  out  ADDR_W  memory address
- memory_data_out  out  DATA_W  memory write data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, STROBE, WAIT, CAPTURE. Every output is registered.
- IDLE: requests are sampled only in this state. If neither request is low, remain in IDLE. If exactly one is low, grant it. If both are low, grant the requester not served last. The last-served pointer resets to scan, so host wins the first tie.
- On grant, register the address, write data (host only) and direction. The scan path is always a read. Go to STROBE.
- STROBE, one cycle:
  - memory_enable_n = 0.
  - memory_write_n = 0 for a write, memory_read_n = 0 for a read.
  - The granted requester's grant_n = 0.
  - The pointer updates to the granted requester.
- Write: STROBE -> IDLE. No valid pulse.
- Read: STROBE -> WAIT. WAIT holds for READ_LAT-1 cycles; with READ_LAT = 1 it is skipped. Then -> CAPTURE.
- CAPTURE: sample memory_data_in into the owner's rdata and go to IDLE.
- Owner's valid_n is low for exactly one cycle, the cycle after CAPTURE. rdata holds its value until the owner's next read.
- Outside STROBE, all strobes and both grant_n are high. memory_address and memory_data_out hold their last values.
- A request withdrawn (req_n high) before its grant is dropped with no access.
- A request still low in the cycle after its grant_n pulse counts as a new request.
- Reset, including mid-access: state returns to IDLE and strobes deassert immediately. No grant or valid is issued for the aborted access.
- Reset values:
  - All *_n outputs = 1.
  - memory_address, memory_data_out, host_rdata, scan_rdata = 0.
  - busy = 0.
  - Pointer = scan.

## Timing
- Request low at edge E (state IDLE) -> STROBE during cycle E+1, with grant_n low in that same cycle.
- Write: IDLE again in cycle E+2. The earliest next STROBE is E+3, so there is one idle cycle between accesses.
- Read with strobe in cycle S:
  - memory_data_in is sampled on the rising edge that ends cycle S+READ_LAT.
  - valid_n is low in cycle S+READ_LAT+1, and the state is IDLE in that same cycle.
  - The earliest next STROBE is S+READ_LAT+2.
- Read latency, request edge to valid: READ_LAT+2 cycles (4 at default).
- Under continuous contention, host and scan strictly alternate; neither waits more than one access.

## Test plan
- Reset then idle: all *_n = 1, busy = 0, memory_address = 0. Assert reset while a read is in WAIT -> strobes high immediately, no valid_n pulse after release.
- Host write of addr 0x3A, data 0xBEEF: exactly one STROBE cycle with enable_n = 0, write_n = 0, address 0x3A, data_out 0xBEEF, host_grant_n low in the same cycle; busy returns low 1 cycle later.
- Scan read of addr 0x05, memory returns 0x1234 at the sample edge, READ_LAT = 2: read_n low one cycle; scan_valid_n low 3 cycles after the strobe with scan_rdata = 0x1234; host_rdata unchanged.
- Both request simultaneously after reset, both held: order is host, scan, host, scan; grants never overlap; no requester is starved.
- Host requests then raises host_req_n before its grant, because a scan access is in progress: no host STROBE occurs, and the scan access completes normally.
- Rerun with READ_LAT = 1 and READ_LAT = 7: valid_n appears 2 and 8 cycles after the strobe respectively; back-to-back reads are spaced READ_LAT+2 cycles apart.

Source files
------------

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one actuator pattern-memory port between the
// host path (read/write) and the scan path (read only).
`timescale 1ns/1ps
module memory_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_req_n,
    input  logic              host_write_n,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_grant_n,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_valid_n,
    input  logic              scan_req_n,
    input  logic [ADDR_W-1:0] scan_address,
    output logic              scan_grant_n,
    output logic [DATA_W-1:0] scan_rdata,
    output logic              scan_valid_n,
    input  logic [DATA_W-1:0] memory_data_in,
    output logic              memory_enable_n,
    output logic              memory_write_n,
    output logic              memory_read_n,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_data_out,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds req_n low until its grant_n pulses low for
    // one cycle (the strobe cycle); requests are only sampled in IDLE, so a
    // request raised before its grant is dropped, and one still low after the
    // grant is a new request. Read data comes back with a one-cycle valid_n.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STROBE  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam logic [2:0] LP_WAIT_INIT = (READ_LAT > 1) ? 3'(READ_LAT - 2) : 3'd0;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_host;
    logic   r_owner_host;
    logic   r_is_write;
    logic [2:0] r_wait_cnt;

    logic w_host_req;
    logic w_scan_req;
    logic w_grant_host;
    logic w_grant_scan;
    logic w_grant_write;
    logic w_start;

    logic w_enable_n;
    logic w_write_n;
    logic w_read_n;
    logic w_host_grant_n;
    logic w_scan_grant_n;
    logic w_host_valid_n;
    logic w_scan_valid_n;
    logic w_busy;

    assign w_host_req    = (r_state == ST_IDLE) && !host_req_n;
    assign w_scan_req    = (r_state == ST_IDLE) && !scan_req_n;
    // On a tie the requester not served last wins.
    assign w_grant_host  = w_host_req && (!w_scan_req || !r_last_host);
    assign w_grant_scan  = w_scan_req && !w_grant_host;
    assign w_grant_write = w_grant_host && !host_write_n;
    assign w_start       = w_grant_host || w_grant_scan;
    assign dbg_state     = r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_next_state = ST_STROBE;
            end
            ST_STROBE: begin
                if (r_is_write)         w_next_state = ST_IDLE;
                else if (READ_LAT == 1) w_next_state = ST_CAPTURE;
                else                    w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == 3'd0) w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; strobes and grants are computed
    // from the transition into STROBE so they are low exactly in that cycle.
    always_comb begin
        w_enable_n     = !w_start;
        w_write_n      = !w_grant_write;
        w_read_n       = !(w_start && !w_grant_write);
        w_host_grant_n = !w_grant_host;
        w_scan_grant_n = !w_grant_scan;
        w_host_valid_n = !((r_state == ST_CAPTURE) && r_owner_host);
        w_scan_valid_n = !((r_state == ST_CAPTURE) && !r_owner_host);
        w_busy         = (w_next_state != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            memory_enable_n <= 1'b1;
            memory_write_n  <= 1'b1;
            memory_read_n   <= 1'b1;
            host_grant_n    <= 1'b1;
            scan_grant_n    <= 1'b1;
            host_valid_n    <= 1'b1;
            scan_valid_n    <= 1'b1;
            busy            <= 1'b0;
        end else begin
            memory_enable_n <= w_enable_n;
            memory_write_n  <= w_write_n;
            memory_read_n   <= w_read_n;
            host_grant_n    <= w_host_grant_n;
            scan_grant_n    <= w_scan_grant_n;
            host_valid_n    <= w_host_valid_n;
            scan_valid_n    <= w_scan_valid_n;
            busy            <= w_busy;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_host     <= 1'b0;
            r_owner_host    <= 1'b0;
            r_is_write      <= 1'b0;
            r_wait_cnt      <= 3'd0;
            memory_address  <= '0;
            memory_data_out <= '0;
            host_rdata      <= '0;
            scan_rdata      <= '0;
        end else begin
            if (w_start) begin
                r_owner_host   <= w_grant_host;
                r_is_write     <= w_grant_write;
                memory_address <= w_grant_host ? host_address : scan_address;
            end
            if (w_grant_write) begin
                memory_data_out <= host_wdata;
            end
            if (r_state == ST_STROBE) begin
                r_last_host <= r_owner_host;
                r_wait_cnt  <= LP_WAIT_INIT;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != 3'd0)) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            if (r_state == ST_CAPTURE) begin
                if (r_owner_host) host_rdata <= memory_data_in;
                else              scan_rdata <= memory_data_in;
            end
        end
    end

endmodule
